// File: rtl/adder_arbiter.sv
// ============================================================================
// adder_arbiter
// ----------------------------------------------------------------------------
// Lets two requesters share a single 4-bit adder datapath.
//
// Operation:
//    - A request sampled in IDLE is arbitrated.
//    - The winner's operands are registered and the winner gets a one-cycle
//      grant pulse.
//    - The adder output is registered one cycle later.
//    - The result is then held on a valid/ready port until the consumer
//      accepts it.
//
// Optional feature macro:
//    ADDER_ARB_ROUND_ROBIN_EN - defined   : round-robin arbitration between
//                                           simultaneous requests
//                               undefined : fixed priority, req0 always wins
//
// Parameters:
//    CNT_W      width of the accepted-result counter op_count
//
// Ports:
//    clk        rising-edge clock
//    rst        asynchronous active-high reset
//    req0/1     request from requester 0/1 (held until its grant is seen)
//    a0/1,b0/1  4-bit operands of requester 0/1
//    gnt0/1     one-cycle grant pulse to requester 0/1
//    out_valid  result available
//    out_ready  consumer accepts the result
//    out_id     requester that owns the current result
//    out_sum    registered 4-bit sum
//    out_cout   registered carry-out
//    op_count   number of accepted results, wraps
// ============================================================================

// ----------------------------------------------------------------------------
// adder: the shared 4-bit combinational adder, no carry-in.
//    a, b  operands
//    sum   low four bits of a + b
//    cout  carry-out of a + b
// ----------------------------------------------------------------------------
module adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] sum,
   output logic       cout
);

   // Both operands are widened so the carry lands in bit 4.
   assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

module adder_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [3:0]       a0,
   input  logic [3:0]       b0,
   output logic             gnt0,
   input  logic             req1,
   input  logic [3:0]       a1,
   input  logic [3:0]       b1,
   output logic             gnt1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_id,
   output logic [3:0]       out_sum,
   output logic             out_cout,
   output logic [CNT_W-1:0] op_count
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      HOLD
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic       take;
   logic       accept;
   logic       win;
   logic [3:0] opa;
   logic [3:0] opb;
   logic [3:0] add_sum;
   logic       add_cout;

   // The shared datapath always sees the registered operands of the current winner.
   adder u_adder (
      .a    (opa),
      .b    (opb),
      .sum  (add_sum),
      .cout (add_cout)
   );

`ifdef ADDER_ARB_ROUND_ROBIN_EN
   logic last_q;

   // On a tie, the requester that was not granted last wins.
   // A lone request simply wins.
   always_comb begin
      win = 1'b0;
      if (req0 && req1) begin
         win = ~last_q;
      end else begin
         win = req1;
      end
   end

   // Remembers the last grant.
   // Resetting it to 1 hands the first tie after reset to requester 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else if (take) begin
         last_q <= win;
      end
   end
`else
   // Fixed priority: requester 1 only wins when requester 0 is quiet.
   always_comb begin
      win = ~req0;
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   // Requests are only looked at in IDLE, so anything raised during CALC or
   // HOLD waits for the next IDLE edge.
   // accept can use HOLD alone because out_valid is always high there.
   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               take    = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            state_d = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               accept  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Grant pulses.
   // Both grants derive from a single winner bit, so they can never be high
   // together.
   // Each grant lasts exactly the one cycle after the sampling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
      end else begin
         gnt0 <= take & ~win;
         gnt1 <= take & win;
      end
   end

   // Operand capture and owner tag, loaded at the grant edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opa    <= 4'd0;
         opb    <= 4'd0;
         out_id <= 1'b0;
      end else if (take) begin
         opa    <= win ? a1 : a0;
         opb    <= win ? b1 : b0;
         out_id <= win;
      end
   end

   // Result register.
   // The result is loaded from the adder while in CALC.
   // It stays untouched until the next operation reaches CALC, which keeps
   // it stable under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_sum   <= 4'd0;
         out_cout  <= 1'b0;
         out_valid <= 1'b0;
      end else if (state_q == CALC) begin
         out_sum   <= add_sum;
         out_cout  <= add_cout;
         out_valid <= 1'b1;
      end else if (accept) begin
         out_valid <= 1'b0;
      end
   end

   // Accepted-result counter.
   // It wraps naturally at its width and is cleared by reset along with any
   // in-flight result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count <= '0;
      end else if (accept) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// ============================================================================
// tb_adder_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for adder_arbiter (built with CNT_W = 2).
//
// A transaction-level model computes the expected outputs from the
// arbitration rules and plain arithmetic.
// A compare process checks every output against that model on each falling
// edge.
// Directed sections add literal expectations, and a random section follows.
// Honours ADDER_ARB_ROUND_ROBIN_EN the same way the design does.
// ============================================================================
module tb_adder_arbiter;

   localparam int TB_CNT_W = 2;

   logic                clk;
   logic                rst;
   logic                req0;
   logic [3:0]          a0;
   logic [3:0]          b0;
   logic                gnt0;
   logic                req1;
   logic [3:0]          a1;
   logic [3:0]          b1;
   logic                gnt1;
   logic                out_valid;
   logic                out_ready;
   logic                out_id;
   logic [3:0]          out_sum;
   logic                out_cout;
   logic [TB_CNT_W-1:0] op_count;

   int checks   = 0;
   int failures = 0;

   adder_arbiter #(.CNT_W(TB_CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0),
      .a0        (a0),
      .b0        (b0),
      .gnt0      (gnt0),
      .req1      (req1),
      .a1        (a1),
      .b1        (b1),
      .gnt1      (gnt1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_id    (out_id),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .op_count  (op_count)
   );

   // 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ------------------------------------------------------------------------
   // Reference model.
   // A transaction is either absent, granted and not yet shown, or shown and
   // waiting to be taken.
   // The 5-bit result is computed with ordinary addition when the grant is
   // made.
   // ------------------------------------------------------------------------
   bit       m_busy   = 0;
   bit       m_shown  = 0;
   int       m_result = 0;
   int       m_last   = 1;
   int       m_win    = 0;
   bit       exp_gnt0 = 0;
   bit       exp_gnt1 = 0;
   bit       exp_valid = 0;
   int       exp_id    = 0;
   int       exp_sum   = 0;
   int       exp_cout  = 0;
   int       exp_count = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy    = 0;
         m_shown   = 0;
         m_last    = 1;
         exp_gnt0  = 0;
         exp_gnt1  = 0;
         exp_valid = 0;
         exp_id    = 0;
         exp_sum   = 0;
         exp_cout  = 0;
         exp_count = 0;
      end else begin
         exp_gnt0 = 0;
         exp_gnt1 = 0;
         if (!m_busy) begin
            if (req0 || req1) begin
`ifdef ADDER_ARB_ROUND_ROBIN_EN
               if (req0 && req1) m_win = (m_last == 1) ? 0 : 1;
               else              m_win = req1 ? 1 : 0;
`else
               m_win = req0 ? 0 : 1;
`endif
               m_last   = m_win;
               m_result = (m_win == 0) ? (int'(a0) + int'(b0))
                                       : (int'(a1) + int'(b1));
               exp_id   = m_win;
               exp_gnt0 = (m_win == 0);
               exp_gnt1 = (m_win == 1);
               m_busy   = 1;
               m_shown  = 0;
            end
         end else if (!m_shown) begin
            exp_sum   = m_result % 16;
            exp_cout  = m_result / 16;
            exp_valid = 1;
            m_shown   = 1;
         end else if (out_ready) begin
            exp_valid = 0;
            exp_count = (exp_count + 1) % (1 << TB_CNT_W);
            m_busy    = 0;
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at time %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Compare process: every output, every cycle, away from the rising edge.
   always @(negedge clk) begin
      checkOutput("m_gnt0",     int'(gnt0),      int'(exp_gnt0));
      checkOutput("m_gnt1",     int'(gnt1),      int'(exp_gnt1));
      checkOutput("gnt_excl",   int'(gnt0 & gnt1), 0);
      checkOutput("m_valid",    int'(out_valid), int'(exp_valid));
      checkOutput("m_id",       int'(out_id),    exp_id);
      checkOutput("m_sum",      int'(out_sum),   exp_sum);
      checkOutput("m_cout",     int'(out_cout),  exp_cout);
      checkOutput("m_op_count", int'(op_count),  exp_count);
   end

   task automatic applyStimulus(input bit r0, input int av0, input int bv0,
                                input bit r1, input int av1, input int bv1,
                                input bit rdy);
      req0      = r0;
      a0        = 4'(av0);
      b0        = 4'(bv0);
      req1      = r1;
      a1        = 4'(av1);
      b1        = 4'(bv1);
      out_ready = rdy;
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int sim_ids[3];

   initial begin
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      tick();
      tick();

      // Reset values.
      checkOutput("rst_valid", int'(out_valid), 0);
      checkOutput("rst_gnt",   int'({gnt1, gnt0}), 0);
      checkOutput("rst_sum",   int'({out_cout, out_sum}), 0);
      checkOutput("rst_id",    int'(out_id), 0);
      checkOutput("rst_count", int'(op_count), 0);
      rst = 1'b0;

      // Single operation: 4 + 3.
      applyStimulus(1, 4, 3, 0, 0, 0, 1);
      tick();
      checkOutput("single_gnt0", int'(gnt0), 1);
      applyStimulus(0, 4, 3, 0, 0, 0, 1);
      tick();
      checkOutput("single_gnt0_drop", int'(gnt0), 0);
      checkOutput("single_valid", int'(out_valid), 1);
      checkOutput("single_sum", int'(out_sum), 7);
      checkOutput("single_cout", int'(out_cout), 0);
      checkOutput("single_id", int'(out_id), 0);
      tick();
      checkOutput("single_done", int'(out_valid), 0);
      checkOutput("single_count", int'(op_count), 1);

      // Carry: 15 + 8 from requester 1.
      applyStimulus(0, 0, 0, 1, 15, 8, 1);
      tick();
      checkOutput("carry_gnt1", int'(gnt1), 1);
      applyStimulus(0, 0, 0, 0, 15, 8, 1);
      tick();
      checkOutput("carry_sum", int'(out_sum), 7);
      checkOutput("carry_cout", int'(out_cout), 1);
      checkOutput("carry_id", int'(out_id), 1);
      tick();

      // 5 + 5.
      applyStimulus(1, 5, 5, 0, 0, 0, 1);
      tick();
      applyStimulus(0, 5, 5, 0, 0, 0, 1);
      tick();
      checkOutput("five_sum", int'(out_sum), 10);
      checkOutput("five_cout", int'(out_cout), 0);
      tick();
      checkOutput("five_count", int'(op_count), 3);

      // Backpressure: 9 + 9, with requester 1 waiting the whole time.
      applyStimulus(1, 9, 9, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 9, 9, 1, 3, 4, 0);
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bp_valid", int'(out_valid), 1);
         checkOutput("bp_sum", int'({out_cout, out_sum}), 18);
         checkOutput("bp_id", int'(out_id), 0);
         checkOutput("bp_no_gnt", int'({gnt1, gnt0}), 0);
      end
      out_ready = 1'b1;
      tick();
      checkOutput("bp_release_valid", int'(out_valid), 0);
      checkOutput("bp_count_wrap", int'(op_count), 0);
      tick();
      checkOutput("bp_next_gnt1", int'(gnt1), 1);
      applyStimulus(0, 0, 0, 0, 3, 4, 1);
      tick();
      checkOutput("bp_next_sum", int'(out_sum), 7);
      tick();
      checkOutput("bp_next_count", int'(op_count), 1);

      // Reset while in CALC.
      applyStimulus(1, 1, 2, 0, 0, 0, 1);
      tick();
      applyStimulus(0, 1, 2, 0, 0, 0, 1);
      rst = 1'b1;
      #1;
      checkOutput("rcalc_valid", int'(out_valid), 0);
      checkOutput("rcalc_gnt", int'({gnt1, gnt0}), 0);
      checkOutput("rcalc_count", int'(op_count), 0);
      tick();
      rst = 1'b0;

      // Reset while in HOLD.
      applyStimulus(1, 1, 2, 0, 0, 0, 0);
      tick();
      applyStimulus(0, 1, 2, 0, 0, 0, 0);
      tick();
      checkOutput("rhold_pre_valid", int'(out_valid), 1);
      rst = 1'b1;
      #1;
      checkOutput("rhold_valid", int'(out_valid), 0);
      checkOutput("rhold_count", int'(op_count), 0);
      checkOutput("rhold_sum", int'(out_sum), 0);
      tick();
      rst = 1'b0;

      // Normal operation after reset: 6 + 7.
      applyStimulus(1, 6, 7, 0, 0, 0, 1);
      tick();
      checkOutput("post_gnt0", int'(gnt0), 1);
      applyStimulus(0, 6, 7, 0, 0, 0, 1);
      tick();
      checkOutput("post_sum", int'(out_sum), 13);
      tick();
      checkOutput("post_count", int'(op_count), 1);

      // Simultaneous requests from a fresh reset.
`ifdef ADDER_ARB_ROUND_ROBIN_EN
      sim_ids = '{0, 1, 0};
`else
      sim_ids = '{0, 0, 0};
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(1, 1, 1, 1, 2, 2, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("sim_gnt", int'({gnt1, gnt0}), (sim_ids[k] == 0) ? 1 : 2);
         tick();
         checkOutput("sim_id", int'(out_id), sim_ids[k]);
         checkOutput("sim_sum", int'(out_sum), (sim_ids[k] == 0) ? 2 : 4);
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      tick();

      // Counter wrap: five accepted operations with a 2-bit counter.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, k, 1, 0, 0, 0, 1);
         tick();
         applyStimulus(0, k, 1, 0, 0, 0, 1);
         tick();
         tick();
      end
      checkOutput("wrap_count", int'(op_count), 1);

      // Random traffic, checked by the compare process.
      for (int c = 0; c < 400; c++) begin
         applyStimulus(($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)),
                       ($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)),
                       ($urandom_range(0, 3) != 0));
         tick();
      end

      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      tick();
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
